// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg -- shared definitions for the NoC merge/arbitration blocks.
//
// Contents:
//   PKT_W            packet width in bits
//   ADDR_HI/ADDR_LO  bounds of the address field inside a packet
//   arb2_state_e     state encoding of the two-input merge arbiter
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int unsigned PKT_W   = 9;
    localparam int unsigned ADDR_HI = 8;
    localparam int unsigned ADDR_LO = 5;

    typedef enum logic [1:0] {
        IDLE,
        SEND_S,
        SEND_OUT
    } arb2_state_e;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2 -- two-requester grant selector.
//
// Ports:
//   req[1:0]  input   request vector
//   last      input   requester granted most recently (tie-break state)
//   gnt[1:0]  output  grant, one-hot or zero
//
// Configuration macro ARB2_MERGE_RR_EN:
//   defined   : on a tie the requester other than 'last' wins (round-robin)
//   undefined : requester 0 always wins a tie; 'last' is ignored
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifndef ARB2_MERGE_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
`ifdef ARB2_MERGE_RR_EN
                gnt = last ? 2'b01 : 2'b10;
`else
                gnt = 2'b01;
`endif
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/arb2_merge.sv
// -----------------------------------------------------------------------------
// arb2_merge -- merges two packet streams into one. Each accepted packet is
// announced first as a winner ID on the s_* channel, then delivered unmodified
// on the out_* channel. One packet is in flight at a time.
//
// Ports:
//   CLK                                 clock, rising edge
//   _RESET                              asynchronous reset, active low
//   in0_data/in0_valid/in0_ready        requester 0 (W bits / 1 / 1)
//   in1_data/in1_valid/in1_ready        requester 1 (W bits / 1 / 1)
//   s_data/s_valid/s_ready              winner ID channel (1 / 1 / 1)
//   out_data/out_valid/out_ready        merged packet channel (W bits / 1 / 1)
//
// Configuration macro ARB2_MERGE_RR_EN:
//   defined   : round-robin tie-break using a last-grant register (reset to 1,
//               so requester 0 wins the first tie)
//   undefined : fixed priority, requester 0 wins ties; no last-grant register
// -----------------------------------------------------------------------------
module arb2_merge
    import noc_pkg::*;
#(
    parameter int unsigned W = PKT_W
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic         s_data,
    output logic         s_valid,
    input  logic         s_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    arb2_state_e  state;
    arb2_state_e  state_nx;
    logic [1:0]   gnt;
    logic         last_grant;
    logic         accept;
    logic         win_q;
    logic [W-1:0] data_q;

    rr_arb2 u_arb (
        .req  ({in1_valid, in0_valid}),
        .last (last_grant),
        .gnt  (gnt)
    );

`ifdef ARB2_MERGE_RR_EN
    logic last_q;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            last_q <= 1'b1;
        end else if (state == SEND_OUT && out_ready) begin
            last_q <= win_q;
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = 1'b1;
`endif

    // Readies are gated by reset as well so they are low for the whole
    // reset interval, not just after the state register has cleared.
    always_comb begin
        state_nx  = state;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        s_valid   = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in0_ready = _RESET & gnt[0];
                in1_ready = _RESET & gnt[1];
                accept    = (in0_valid & in0_ready) | (in1_valid & in1_ready);
                if (accept) begin
                    state_nx = SEND_S;
                end
            end
            SEND_S: begin
                s_valid = 1'b1;
                if (s_ready) begin
                    state_nx = SEND_OUT;
                end
            end
            SEND_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state  <= IDLE;
            win_q  <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                win_q  <= gnt[1];
                data_q <= gnt[1] ? in1_data : in0_data;
            end
        end
    end

    assign s_data   = win_q;
    assign out_data = data_q;

endmodule

// File: tb/tb_arb2_merge.sv
// -----------------------------------------------------------------------------
// tb_arb2_merge -- self-checking bench for arb2_merge. Builds with or without
// ARB2_MERGE_RR_EN; expectations follow the same macro.
// -----------------------------------------------------------------------------
module tb_arb2_merge;
    import noc_pkg::*;

    localparam int unsigned W = PKT_W;

    logic         CLK = 1'b0;
    logic         _RESET;
    logic [W-1:0] in0_data, in1_data, out_data;
    logic         in0_valid, in0_ready, in1_valid, in1_ready;
    logic         s_data, s_valid, s_ready, out_valid, out_ready;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    arb2_merge #(.W(W)) dut (
        .CLK       (CLK),
        ._RESET    (_RESET),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic         rst;
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic         sr;
        logic         orr;
        logic         r0;
        logic         r1;
        logic         sv;
        logic         sd;
        logic         ov;
        logic [W-1:0] od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic v0, input logic [W-1:0] d0,
                                input logic v1, input logic [W-1:0] d1,
                                input logic sr, input logic orr,
                                input logic r0, input logic r1, input logic sv,
                                input logic sd, input logic ov, input logic [W-1:0] od);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.sr = sr; v.orr = orr; v.r0 = r0; v.r1 = r1; v.sv = sv;
        v.sd = sd; v.ov = ov; v.od = od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Data/ID are only compared while their valid is expected high.
    task automatic chk_outs(input string tag, input logic r0, input logic r1,
                            input logic sv, input logic sd, input logic ov,
                            input logic [W-1:0] od);
        chk({tag, ".in0_ready"}, W'(in0_ready), W'(r0));
        chk({tag, ".in1_ready"}, W'(in1_ready), W'(r1));
        chk({tag, ".s_valid"},   W'(s_valid),   W'(sv));
        chk({tag, ".out_valid"}, W'(out_valid), W'(ov));
        if (sv) chk({tag, ".s_data"}, W'(s_data), W'(sd));
        if (ov) chk({tag, ".out_data"}, out_data, od);
    endtask

    task automatic set_in(input logic v0, input logic [W-1:0] d0, input logic v1,
                          input logic [W-1:0] d1, input logic sr, input logic orr);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        s_ready = sr; out_ready = orr;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        _RESET = 1'b0;
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1 _RESET = 1'b1;
    endtask

    initial begin
        int            w;
        logic [W-1:0]  d;
        logic          sv0, sv1, sr, orr;
        logic [W-1:0]  sd0, sd1;
        logic          m_has, m_sent, m_who, m_last;
        logic [W-1:0]  m_pkt;
        logic          e_r0, e_r1, e_sv, e_ov;
        int            delivered;

        // ---- reset state, with every input trying to provoke activity ----
        _RESET = 1'b0;
        set_in(1'b1, 9'h1AA, 1'b1, 9'h055, 1'b1, 1'b1);
        #2;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("reset.s_data", W'(s_data), '0);
        chk("reset.out_data", out_data, '0);
        repeat (2) @(posedge CLK);
        #1;
        chk_outs("reset_clk", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // ---- vector table: single request, then a sustained tie ----
        vecs.push_back(mk(1, 1, 9'h0C5, 0, '0, 1, 1, 1, 0, 0, 0, 0, '0));
        vecs.push_back(mk(0, 0, '0, 0, '0, 1, 1, 0, 0, 1, 0, 0, '0));
        vecs.push_back(mk(0, 0, '0, 0, '0, 1, 1, 0, 0, 0, 0, 1, 9'h0C5));
        vecs.push_back(mk(0, 0, '0, 0, '0, 1, 1, 0, 0, 0, 0, 0, '0));
        for (int k = 0; k < 4; k++) begin
`ifdef ARB2_MERGE_RR_EN
            w = k % 2;
`else
            w = 0;
`endif
            d = (w == 1) ? 9'h122 : 9'h011;
            vecs.push_back(mk(k == 0, 1, 9'h011, 1, 9'h122, 1, 1, w == 0, w == 1, 0, 0, 0, '0));
            vecs.push_back(mk(0, 1, 9'h011, 1, 9'h122, 1, 1, 0, 0, 1, w[0], 0, '0));
            vecs.push_back(mk(0, 1, 9'h011, 1, 9'h122, 1, 1, 0, 0, 0, 0, 1, d));
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else cyc();
            set_in(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].sr, vecs[i].orr);
            #2;
            chk_outs($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].sv,
                     vecs[i].sd, vecs[i].ov, vecs[i].od);
        end

        // ---- backpressure on both output channels ----
        do_reset();
        set_in(1'b1, 9'h0A5, 1'b1, 9'h15A, 1'b0, 1'b0);
        #2 chk_outs("bp_acc", 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            cyc(); set_in(1'b0, '0, 1'b1, 9'h15A, 1'b0, 1'b0);
            #2 chk_outs("bp_s_hold", 0, 0, 1, 0, 0, '0);
        end
        cyc(); set_in(1'b0, '0, 1'b1, 9'h15A, 1'b1, 1'b0);
        #2 chk_outs("bp_s_ack", 0, 0, 1, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            cyc(); set_in(1'b0, '0, 1'b1, 9'h15A, 1'b0, 1'b0);
            #2 chk_outs("bp_out_hold", 0, 0, 0, 0, 1, 9'h0A5);
        end
        cyc(); set_in(1'b0, '0, 1'b1, 9'h15A, 1'b0, 1'b1);
        #2 chk_outs("bp_out_ack", 0, 0, 0, 0, 1, 9'h0A5);
        cyc(); set_in(1'b0, '0, 1'b1, 9'h15A, 1'b0, 1'b0);
        #2 chk_outs("bp_next", 0, 1, 0, 0, 0, '0);

        // ---- asynchronous reset while a packet from input 1 is in SEND_OUT ----
        do_reset();
        set_in(1'b1, 9'h033, 1'b0, '0, 1'b1, 1'b1);
        #2 chk_outs("ro_a_acc", 1, 0, 0, 0, 0, '0);
        cyc(); set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        #2 chk_outs("ro_a_s", 0, 0, 1, 0, 0, '0);
        cyc();
        #2 chk_outs("ro_a_out", 0, 0, 0, 0, 1, 9'h033);
        cyc(); set_in(1'b0, '0, 1'b1, 9'h1F0, 1'b1, 1'b0);
        #2 chk_outs("ro_b_acc", 0, 1, 0, 0, 0, '0);
        cyc(); set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        #2 chk_outs("ro_b_s", 0, 0, 1, 1, 0, '0);
        cyc(); set_in(1'b1, 9'h011, 1'b1, 9'h122, 1'b1, 1'b0);
        #2 chk_outs("ro_b_out", 0, 0, 0, 0, 1, 9'h1F0);
        #1 _RESET = 1'b0;
        #1 chk_outs("ro_in_reset", 0, 0, 0, 0, 0, '0);
        chk("ro_in_reset.s_data", W'(s_data), '0);
        chk("ro_in_reset.out_data", out_data, '0);
        @(posedge CLK);
        #1 _RESET = 1'b1;
        set_in(1'b1, 9'h011, 1'b1, 9'h122, 1'b1, 1'b1);
        #2 chk_outs("ro_after", 1, 0, 0, 0, 0, '0);

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        sv0 = 1'b0; sv1 = 1'b0; sd0 = '0; sd1 = '0;
        m_has = 1'b0; m_sent = 1'b0; m_who = 1'b0; m_last = 1'b1; m_pkt = '0;
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) cyc();
            if (!sv0 && $urandom_range(0, 2) == 0) begin sv0 = 1'b1; sd0 = W'($urandom); end
            if (!sv1 && $urandom_range(0, 2) == 0) begin sv1 = 1'b1; sd1 = W'($urandom); end
            sr  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) != 0);
            set_in(sv0, sd0, sv1, sd1, sr, orr);

            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (!m_has) begin
                if (sv0 && sv1) begin
`ifdef ARB2_MERGE_RR_EN
                    if (m_last) e_r0 = 1'b1;
                    else e_r1 = 1'b1;
`else
                    e_r0 = 1'b1;
`endif
                end else if (sv0) begin
                    e_r0 = 1'b1;
                end else if (sv1) begin
                    e_r1 = 1'b1;
                end
            end
            e_sv = m_has && !m_sent;
            e_ov = m_has && m_sent;

            #2 chk_outs("rnd", e_r0, e_r1, e_sv, m_who, e_ov, m_pkt);

            if (e_r0) begin
                m_has = 1'b1; m_sent = 1'b0; m_pkt = sd0; m_who = 1'b0; sv0 = 1'b0;
            end else if (e_r1) begin
                m_has = 1'b1; m_sent = 1'b0; m_pkt = sd1; m_who = 1'b1; sv1 = 1'b0;
            end else if (e_sv && sr) begin
                m_sent = 1'b1;
            end else if (e_ov && orr) begin
                m_has = 1'b0; m_last = m_who; delivered++;
            end
        end
        chk("rnd_progress", W'(delivered > 100), W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
